// File: rtl/blake_pkg.sv
// Shared types and constants for the BLAKE-512 round sequencer: state layout, counter width,
// FSM encoding and the G-operand to working-word mapping.
package blake_pkg;

  localparam int unsigned NUM_ROUNDS      = 16;
  localparam int unsigned STEPS_PER_ROUND = 4;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned WORD_W          = 64;
  localparam int unsigned NUM_WORDS       = 16;
  localparam int unsigned STATE_W         = WORD_W * NUM_WORDS;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS * STEPS_PER_ROUND - 1);

  // Word n occupies v[V_LSB[n]+63 : V_LSB[n]]; v0 is the most significant word.
  localparam int unsigned V_LSB [NUM_WORDS] = '{
    960, 896, 832, 768, 704, 640, 576, 512,
    448, 384, 320, 256, 192, 128,  64,   0
  };

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

  // Word index fed by G unit g, operand pos (a..d = 0..3), at step s.
  // Column steps use column {s[0], g}; diagonal steps rotate the column by the operand row.
  function automatic logic [3:0] word_idx(logic [1:0] step, logic g, logic [1:0] pos);
    logic [1:0] col;
    col = {step[0], g} + (step[1] ? pos : 2'd0);
    return {pos, col};
  endfunction

endpackage

// File: rtl/blake_state_writeback.sv
// Combinational write-back: scatters the eight G results into the working state according to
// the current step's column/diagonal mapping; all other words pass through.
module blake_state_writeback
  import blake_pkg::*;
(
  input  logic [STATE_W-1:0]       v_cur,
  input  logic [1:0]               step,
  input  logic [7:0][WORD_W-1:0]   g_res,
  output logic [STATE_W-1:0]       v_next
);

  always_comb begin
    v_next = v_cur;
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < 4; p++) begin
        v_next[V_LSB[word_idx(step, 1'(g), 2'(p))] +: WORD_W] = g_res[3'(g * 4 + p)];
      end
    end
  end

endmodule

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 round sequencer: owns the working state v, steps counter_idx through 16 rounds of
// 4 steps and writes both G-unit results back, with start/busy/done handshake and abort.
module blake_round_ctrl
  import blake_pkg::*;
#(
  parameter int unsigned G_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [STATE_W-1:0] v_init,
  input  logic [WORD_W-1:0]  a1_out,
  input  logic [WORD_W-1:0]  b1_out,
  input  logic [WORD_W-1:0]  c1_out,
  input  logic [WORD_W-1:0]  d1_out,
  input  logic [WORD_W-1:0]  a2_out,
  input  logic [WORD_W-1:0]  b2_out,
  input  logic [WORD_W-1:0]  c2_out,
  input  logic [WORD_W-1:0]  d2_out,
  output logic [STATE_W-1:0] v_out,
  output logic [CNT_W-1:0]   counter_idx,
  output logic [3:0]         round_idx,
  output logic               g_issue,
  output logic               busy,
  output logic               done
);

  localparam int unsigned WAIT_W = (G_LAT > 1) ? $clog2(G_LAT) : 1;

  state_e             state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [STATE_W-1:0] v_next;
  logic               wb;

  blake_state_writeback u_writeback (
    .v_cur  (v_out),
    .step   (counter_idx[1:0]),
    .g_res  ({d2_out, c2_out, b2_out, a2_out, d1_out, c1_out, b1_out, a1_out}),
    .v_next (v_next)
  );

  // G results are consumed at the last edge of each step: the issue edge for combinational G,
  // otherwise the edge on which the wait counter has run out.
  always_comb begin
    wb = !abort && (((state_q == StRun) && (G_LAT == 0)) ||
                    ((state_q == StWait) && (wait_q == '0)));
  end

  assign g_issue   = (state_q == StRun);
  assign round_idx = counter_idx[5:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      v_out       <= '0;
      counter_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start && !abort) begin
            state_q     <= StRun;
            v_out       <= v_init;
            counter_idx <= '0;
            busy        <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun, StWait: begin
          if (abort) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            counter_idx <= '0;
          end else if (wb) begin
            v_out       <= v_next;
            counter_idx <= counter_idx + 1'b1;
            if (counter_idx == LAST_IDX) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q <= StRun;
            end
          end else if (state_q == StRun) begin
            wait_q  <= WAIT_W'(G_LAT - 1);
            state_q <= StWait;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Self-checking bench for blake_round_ctrl: stub G units driven from v_out, results compared
// against a word-array model of the 64-step schedule.
module tb_blake_round_ctrl;

  localparam int MAP [4][8] = '{
    '{0, 4,  8, 12, 1, 5,  9, 13},
    '{2, 6, 10, 14, 3, 7, 11, 15},
    '{0, 5, 10, 15, 1, 6, 11, 12},
    '{2, 7,  8, 13, 3, 4,  9, 14}
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          gmode;
  logic [63:0] gk;
  logic        start0, abort0, start2, abort2;
  logic [1023:0] v_init;

  logic [1023:0] v_out0, v_out2;
  logic [5:0]    cidx0, cidx2;
  logic [3:0]    ridx0, ridx2;
  logic          iss0, iss2, busy0, busy2, done0, done2;
  logic [63:0]   g0 [8];
  logic [63:0]   g2o [8];

  function automatic logic [63:0] word(input logic [1023:0] v, input int i);
    return v[(15 - i) * 64 +: 64];
  endfunction

  // mode 0: identity, mode 1: add k, mode 2: position/step tag
  function automatic logic [63:0] gfun(input int mode, input logic [63:0] k, input logic [63:0] x,
                                       input int s, input int j);
    if (mode == 0) return x;
    if (mode == 1) return x + k;
    return (64'(j + 1) << 8) | 64'(s);
  endfunction

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      g0[j]  = gfun(gmode, gk, word(v_out0, MAP[cidx0[1:0]][j]), int'(cidx0[1:0]), j);
      g2o[j] = gfun(gmode, gk, word(v_out2, MAP[cidx2[1:0]][j]), int'(cidx2[1:0]), j);
    end
  end

  blake_round_ctrl #(.G_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .v_init(v_init),
    .a1_out(g0[0]), .b1_out(g0[1]), .c1_out(g0[2]), .d1_out(g0[3]),
    .a2_out(g0[4]), .b2_out(g0[5]), .c2_out(g0[6]), .d2_out(g0[7]),
    .v_out(v_out0), .counter_idx(cidx0), .round_idx(ridx0), .g_issue(iss0),
    .busy(busy0), .done(done0)
  );

  blake_round_ctrl #(.G_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .v_init(v_init),
    .a1_out(g2o[0]), .b1_out(g2o[1]), .c1_out(g2o[2]), .d1_out(g2o[3]),
    .a2_out(g2o[4]), .b2_out(g2o[5]), .c2_out(g2o[6]), .d2_out(g2o[7]),
    .v_out(v_out2), .counter_idx(cidx2), .round_idx(ridx2), .g_issue(iss2),
    .busy(busy2), .done(done2)
  );

  // Reference: apply nsteps of the schedule to a plain array of 16 words.
  function automatic logic [1023:0] model(input logic [1023:0] vi, input int mode,
                                          input logic [63:0] k, input int nsteps);
    logic [63:0]   m [16];
    logic [1023:0] vo;
    for (int i = 0; i < 16; i++) m[i] = word(vi, i);
    for (int st = 0; st < nsteps; st++) begin
      for (int j = 0; j < 8; j++) m[MAP[st % 4][j]] = gfun(mode, k, m[MAP[st % 4][j]], st % 4, j);
    end
    for (int i = 0; i < 16; i++) vo[(15 - i) * 64 +: 64] = m[i];
    return vo;
  endfunction

  function automatic logic [1023:0] seq_vec(input int add);
    logic [1023:0] v;
    for (int i = 0; i < 16; i++) v[(15 - i) * 64 +: 64] = 64'(i + add);
    return v;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i * 32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int w;
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      w = 0;
      for (int i = 15; i >= 0; i--) if (word(got, i) !== word(exp, i)) w = i;
      $error("FAIL %s word%0d got=%h exp=%h", tag, w, word(got, w), word(exp, w));
    end
  endtask

  task automatic launch(input int which, input logic [1023:0] vi);
    v_init = vi;
    if (which != 0) start2 = 1'b1;
    else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Called at the sample right after the accept edge; returns at the done sample.
  task automatic wait_done(input int which, input int poke_at, input logic [1023:0] vb,
                           output int cyc, output int iss_n);
    cyc   = 0;
    iss_n = 0;
    while (!((which != 0) ? done2 : done0) && cyc < 400) begin
      if ((which != 0) ? iss2 : iss0) iss_n++;
      if (cyc == poke_at) begin
        v_init = vb;
        if (which != 0) start2 = 1'b1;
        else start0 = 1'b1;
      end
      tick();
      start0 = 1'b0;
      start2 = 1'b0;
      cyc++;
    end
  endtask

  task automatic run_to_idx(input logic [5:0] target);
    int n;
    n = 0;
    while (cidx0 != target && n < 200) begin
      tick();
      n++;
    end
    chk("reach_idx", 64'(cidx0), 64'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1023:0] vi, vb, vc;
    int cyc, iss_n;
    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    gmode = 0; gk = '0; v_init = '0;
    repeat (3) tick();
    chk_v("rst_v", v_out0, '0);
    chk("rst_cidx", 64'(cidx0), 0);
    chk("rst_issue", 64'(iss0), 0);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_done", 64'(done0), 0);
    chk("rst_busy2", 64'(busy2), 0);
    rst = 1'b0;
    tick();

    // Identity G
    vi = seq_vec(0);
    gmode = 0;
    launch(0, vi);
    chk("t1_busy", 64'(busy0), 1);
    chk("t1_issue", 64'(iss0), 1);
    chk("t1_cidx", 64'(cidx0), 0);
    wait_done(0, -1, '0, cyc, iss_n);
    chk("t1_latency", 64'(cyc), 64);
    chk("t1_issues", 64'(iss_n), 64);
    chk_v("t1_v", v_out0, vi);
    chk("t1_busy_done", 64'(busy0), 0);
    chk("t1_cidx_wrap", 64'(cidx0), 0);
    tick();
    chk("t1_done_pulse", 64'(done0), 0);

    // +1 stub: every word hit twice per round
    gmode = 1; gk = 64'd1;
    launch(0, seq_vec(0));
    wait_done(0, -1, '0, cyc, iss_n);
    chk("t2_latency", 64'(cyc), 64);
    chk_v("t2_v", v_out0, seq_vec(32));
    tick();

    // Random v_init and adder constant
    for (int r = 0; r < 3; r++) begin
      vi = rand_vec();
      gk = {$urandom(), $urandom()};
      launch(0, vi);
      wait_done(0, -1, '0, cyc, iss_n);
      chk("rnd_latency", 64'(cyc), 64);
      chk_v("rnd_v", v_out0, model(vi, 1, gk, 64));
      tick();
    end

    // G_LAT = 2
    gk = 64'd1;
    launch(2, seq_vec(0));
    chk("t3_issue0", 64'(iss2), 1);
    wait_done(2, -1, '0, cyc, iss_n);
    chk("t3_latency", 64'(cyc), 192);
    chk("t3_issues", 64'(iss_n), 64);
    chk_v("t3_v", v_out2, seq_vec(32));
    chk("t3_busy_done", 64'(busy2), 0);
    tick();

    // Tag stub: only the mapped words change per step
    gmode = 2;
    vi = rand_vec();
    launch(0, vi);
    for (int k = 1; k <= 8; k++) begin
      chk("t4_round", 64'(ridx0), 64'((k - 1) / 4));
      tick();
      chk_v("t4_step_v", v_out0, model(vi, 2, '0, k));
      chk("t4_cidx", 64'(cidx0), 64'(k));
    end
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    chk_v("t4_abort_hold", v_out0, model(vi, 2, '0, 8));
    chk("t4_abort_busy", 64'(busy0), 0);

    // Abort at counter_idx 37, then restart
    gmode = 1; gk = 64'd1;
    launch(0, seq_vec(0));
    run_to_idx(6'd37);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    chk("t5_busy", 64'(busy0), 0);
    chk("t5_done", 64'(done0), 0);
    chk("t5_issue", 64'(iss0), 0);
    chk("t5_cidx", 64'(cidx0), 0);
    repeat (3) tick();
    chk("t5_no_done", 64'(done0), 0);
    launch(0, seq_vec(0));
    wait_done(0, -1, '0, cyc, iss_n);
    chk("t5_restart_latency", 64'(cyc), 64);
    chk_v("t5_restart_v", v_out0, seq_vec(32));
    tick();

    // Asynchronous reset mid-run
    launch(0, rand_vec());
    run_to_idx(6'd20);
    rst = 1'b1;
    #1;
    chk_v("t6_rst_v", v_out0, '0);
    chk("t6_rst_busy", 64'(busy0), 0);
    chk("t6_rst_cidx", 64'(cidx0), 0);
    chk("t6_rst_issue", 64'(iss0), 0);
    tick();
    rst = 1'b0;
    tick();

    // Start while busy is ignored; start in the done cycle chains a new run
    vb = rand_vec();
    launch(0, seq_vec(0));
    wait_done(0, 5, vb, cyc, iss_n);
    chk("t6_busy_start_latency", 64'(cyc), 64);
    chk_v("t6_busy_start_v", v_out0, seq_vec(32));
    vc = rand_vec();
    launch(0, vc);
    chk("t6_chain_busy", 64'(busy0), 1);
    chk("t6_chain_done", 64'(done0), 0);
    chk("t6_chain_cidx", 64'(cidx0), 0);
    chk_v("t6_chain_vinit", v_out0, vc);
    wait_done(0, -1, '0, cyc, iss_n);
    chk("t6_chain_latency", 64'(cyc), 64);
    chk_v("t6_chain_v", v_out0, model(vc, 1, 64'd1, 64));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
